fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Owns the PC register and issues in-order requests to instruction memory over a req/gnt/rvalid handshake with variable latency.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode as inst/pc/valid.
- Honours decode back-pressure (stall) and branch/jump redirects, discarding wrong-path responses still in flight.

Parameters:
RESET_PC, 32'hBFC0_0000, first fetch address after reset
DEPTH, 2, instruction buffer entries; also the maximum of (outstanding requests + buffered entries)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset; asynchronous, active-high
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch address; word aligned
imem_gnt  input  1  memory accepts request this cycle
imem_rvalid  input  1  response valid; responses return in request order
imem_rdata  input  32  response instruction word
stall_d  input  1  decode cannot accept an instruction this cycle
redirect  input  1  branch/jump taken; restart fetch
redirect_pc  input  32  new fetch PC; bits [1:0] ignored and treated as 0
inst_f  output  32  instruction at buffer head
pc_f  output  32  PC of inst_f
valid_f  output  1  inst_f/pc_f valid

Behaviour:
- Reset (asynchronous, active-high): all counters and FIFO pointers are cleared.
  - pc = RESET_PC, outstanding = 0, drop = 0, buffer empty.
  - valid_f = 0, inst_f = 0, pc_f = 0, imem_req = 0.
  - imem_addr = RESET_PC during reset.
- Request issue:
  - imem_addr = pc at all times.
  - imem_req = !rst && !redirect && (outstanding + drop + count - pop) < DEPTH.
  - pop = valid_f && !stall_d.
  - Once raised, req and addr hold stable until imem_gnt, unless a redirect occurs.
- Grant (imem_req && imem_gnt):
  - pc <= pc + 4, wrapping modulo 2^32.
  - The granted pc is pushed into an internal tag FIFO (DEPTH entries).
  - outstanding increments.
- Response (imem_rvalid):
  - If drop > 0: drop decrements and the response is discarded.
  - Otherwise: the tag FIFO is popped, {tag, imem_rdata} is written to the instruction buffer, and outstanding decrements.
  - A grant and a response in the same cycle leave outstanding unchanged.
- Output:
  - inst_f/pc_f/valid_f are registered from the buffer head.
  - An entry written on edge N is visible after edge N and is held while stall_d = 1.
  - On pop the head advances; the buffer is read and written in the same cycle.
- Redirect (single-cycle pulse):
  - On the next edge: pc <= {redirect_pc[31:2], 2'b00}, buffer and tag FIFO flushed, valid_f <= 0.
  - drop <= drop + outstanding, minus 1 if a non-dropped rvalid arrives in the same cycle.
  - outstanding <= 0.
  - The cycle-of-redirect response is discarded.
  - imem_req is 0 in the redirect cycle, so no grant can occur.
  - The first new request is issued the cycle after.
- Redirect priority:
  - redirect beats stall_d.
  - The head instruction is not consumed in the redirect cycle; decode ignores valid_f when it redirects.
- Latency and throughput:
  - With a memory that grants the same cycle and returns rvalid the next cycle, valid_f rises 2 cycles after the first request cycle.
  - Throughput is 1 instruction/cycle with stall_d = 0 and DEPTH >= 2.
- Invariant: outstanding + drop + count <= DEPTH. An rvalid with no outstanding request and drop = 0 is a protocol error; the implementation asserts on it in simulation.
- Reset mid-transaction: all state is cleared immediately; later rvalids for pre-reset requests are outside the protocol and are not required to be handled.

Test Plan:
- Reset release, 1-cycle memory returning word = addr, stall_d = 0:
  - Required: imem_addr sequence 0xBFC00000, 0xBFC00004, 0xBFC00008, ...
  - Required: valid_f high from cycle 2 with pc_f = inst_f advancing by 4 every cycle.
- stall_d held high for 5 cycles during streaming:
  - Required: inst_f/pc_f frozen, imem_req drops once outstanding + count = 2.
  - Required: no instruction lost or duplicated on release; PCs are contiguous.
- Memory with 3-cycle response latency and gnt delayed 2 cycles:
  - Required: imem_addr is stable while req is waiting for gnt.
  - Required: never more than 2 requests outstanding; in-order pc_f.
- Redirect to 0x00400013 while 2 requests are outstanding:
  - Required: the next imem_addr is 0x00400010; both stale responses are discarded.
  - Required: the first valid_f after the redirect carries pc_f = 0x00400010.
- Redirect in the same cycle as rvalid and stall_d = 1:
  - Required: valid_f = 0 the next cycle, that response is dropped, and drop accounting returns to 0.
- Fetch at pc = 0xFFFFFFFC:
  - Required: the next imem_addr is 0x00000000 (wrap).
- Async rst asserted mid-stream:
  - Required: valid_f and imem_req go low without waiting for a clock edge; pc = RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction fetch with variable-latency imem handshake, in-order
//            response buffering and redirect with wrong-path response drop.
// Revision : 1.0
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall_d,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst_f,
  output logic [31:0] pc_f,
  output logic        valid_f
);

  localparam int CW   = $clog2(DEPTH + 1);
  localparam int TW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SK   = (DEPTH > 1) ? DEPTH - 1 : 1;
  localparam int SW   = (SK > 1) ? $clog2(SK) : 1;
  localparam int SUMW = CW + 2;
  localparam logic [SUMW-1:0] c_depth = SUMW'(DEPTH);

  logic [31:0]   r_pc;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_drop;
  logic [31:0]   r_tag_mem [0:(1<<TW)-1];
  logic [TW-1:0] r_tag_wr;
  logic [TW-1:0] r_tag_rd;

  // Head entry lives in the output registers; the skid FIFO holds the rest.
  logic          r_valid_f;
  logic [31:0]   r_inst_f;
  logic [31:0]   r_pc_f;
  logic [31:0]   r_skid_pc   [0:(1<<SW)-1];
  logic [31:0]   r_skid_inst [0:(1<<SW)-1];
  logic [SW-1:0] r_skid_wr;
  logic [SW-1:0] r_skid_rd;
  logic [CW-1:0] r_skid_cnt;

  logic            w_grant;
  logic            w_drop_rsp;
  logic            w_accept;
  logic            w_pop;
  logic            w_head_free;
  logic            w_skid_nonempty;
  logic            w_skid_rd_en;
  logic            w_skid_wr_en;
  logic [31:0]     w_tag_head;
  logic [SUMW-1:0] w_count;
  logic [SUMW-1:0] w_inflight;
  logic            w_unused;

  function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
    return (p == TW'(DEPTH - 1)) ? '0 : p + TW'(1);
  endfunction

  function automatic logic [SW-1:0] skid_inc(input logic [SW-1:0] p);
    return (p == SW'(SK - 1)) ? '0 : p + SW'(1);
  endfunction

  assign w_grant         = imem_req & imem_gnt;
  assign w_drop_rsp      = imem_rvalid & (r_drop != '0);
  assign w_accept        = imem_rvalid & (r_drop == '0) & ~redirect;
  assign w_pop           = r_valid_f & ~stall_d;
  assign w_head_free     = ~r_valid_f | ~stall_d;
  assign w_skid_nonempty = (r_skid_cnt != '0);
  assign w_skid_rd_en    = w_head_free & w_skid_nonempty;
  assign w_skid_wr_en    = w_accept & ~(w_head_free & ~w_skid_nonempty);
  assign w_tag_head      = r_tag_mem[r_tag_rd];

  assign w_count    = SUMW'(r_skid_cnt) + SUMW'(r_valid_f);
  assign w_inflight = SUMW'(r_out) + SUMW'(r_drop) + w_count - SUMW'(w_pop);

  assign imem_req  = ~rst & ~redirect & (w_inflight < c_depth);
  assign imem_addr = r_pc;
  assign inst_f    = r_inst_f;
  assign pc_f      = r_pc_f;
  assign valid_f   = r_valid_f;
  assign w_unused  = ^redirect_pc[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_out    <= '0;
      r_drop   <= '0;
      r_tag_wr <= '0;
      r_tag_rd <= '0;
    end else if (redirect) begin
      // Everything still in flight becomes wrong-path, including this cycle's response.
      r_pc     <= {redirect_pc[31:2], 2'b00};
      r_out    <= '0;
      r_drop   <= r_drop + r_out - CW'(imem_rvalid);
      r_tag_wr <= '0;
      r_tag_rd <= '0;
    end else begin
      if (w_grant) begin
        r_pc     <= r_pc + 32'd4;
        r_tag_wr <= tag_inc(r_tag_wr);
      end
      if (w_accept) begin
        r_tag_rd <= tag_inc(r_tag_rd);
      end
      if (w_drop_rsp) begin
        r_drop <= r_drop - CW'(1);
      end
      r_out <= r_out + CW'(w_grant) - CW'(w_accept);
    end
  end

  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_tag_mem[r_tag_wr] <= r_pc;
    end
    if (w_skid_wr_en) begin
      r_skid_pc[r_skid_wr]   <= w_tag_head;
      r_skid_inst[r_skid_wr] <= imem_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid_f  <= 1'b0;
      r_inst_f   <= '0;
      r_pc_f     <= '0;
      r_skid_wr  <= '0;
      r_skid_rd  <= '0;
      r_skid_cnt <= '0;
    end else if (redirect) begin
      r_valid_f  <= 1'b0;
      r_skid_wr  <= '0;
      r_skid_rd  <= '0;
      r_skid_cnt <= '0;
    end else begin
      if (w_head_free) begin
        if (w_skid_nonempty) begin
          r_valid_f <= 1'b1;
          r_inst_f  <= r_skid_inst[r_skid_rd];
          r_pc_f    <= r_skid_pc[r_skid_rd];
        end else if (w_accept) begin
          r_valid_f <= 1'b1;
          r_inst_f  <= imem_rdata;
          r_pc_f    <= w_tag_head;
        end else begin
          r_valid_f <= 1'b0;
        end
      end
      if (w_skid_rd_en) begin
        r_skid_rd <= skid_inc(r_skid_rd);
      end
      if (w_skid_wr_en) begin
        r_skid_wr <= skid_inc(r_skid_wr);
      end
      r_skid_cnt <= r_skid_cnt + CW'(w_skid_wr_en) - CW'(w_skid_rd_en);
    end
  end

`ifndef SYNTHESIS
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
    !(imem_rvalid && (r_out == '0) && (r_drop == '0)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Directed + random bench for fetch_stage against a queue model.
// Revision : 1.0
// ============================================================================
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_gnt, imem_rvalid, stall_d, redirect, valid_f;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, inst_f, pc_f;

  fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall_d(stall_d), .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_f(inst_f), .pc_f(pc_f), .valid_f(valid_f)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int epoch; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

  mreq_t       memq[$];
  ent_t        bq[$];
  int          checks = 0, errors = 0;
  int          cyc = 0, epoch = 0, lat = 1, gnt_delay = 0, req_wait = 0, max_inflight = 0;
  bit          gnt_random = 0, word_is_addr = 1;
  logic [31:0] mpc, consume_pc, hold_pc;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return word_is_addr ? a : ({a[15:0], a[31:16]} ^ 32'h5A3C_96E1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check, advance the reference model.
  task automatic do_cycle(input logic st, input logic rd, input logic [31:0] rpc);
    logic  grant, accept, pop, exp_req;
    mreq_t r;
    stall_d     = st;
    redirect    = rd;
    redirect_pc = rpc;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memword(memq[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    if (imem_req)
      imem_gnt = (req_wait >= gnt_delay) && (!gnt_random || ($urandom_range(0, 3) != 0));
    else
      imem_gnt = gnt_random ? ($urandom_range(0, 1) == 1) : 1'b0;
    #1;
    if (memq.size() + bq.size() > max_inflight) max_inflight = memq.size() + bq.size();
    pop     = !rd && (bq.size() > 0) && !st;
    exp_req = !rd && ((memq.size() + bq.size() - (pop ? 1 : 0)) < DEPTH);
    chk("imem_req", imem_req, exp_req);
    chk("imem_addr", imem_addr, mpc);
    chk("valid_f", valid_f, bq.size() > 0);
    if (bq.size() > 0) begin
      chk("pc_f", pc_f, bq[0].pc);
      chk("inst_f", inst_f, bq[0].inst);
    end
    if (pop) begin
      chk("consume_order", pc_f, consume_pc);
      consume_pc += 32'd4;
    end
    grant  = imem_req && imem_gnt;
    accept = 1'b0;
    if (imem_rvalid) begin
      r = memq.pop_front();
      accept = !rd && (r.epoch == epoch);
    end
    if (pop) bq.delete(0);
    if (accept) bq.push_back('{r.addr, memword(r.addr)});
    if (grant) begin
      memq.push_back('{mpc, epoch, cyc + lat});
      mpc += 32'd4;
    end
    if (imem_req && !imem_gnt) req_wait++;
    else req_wait = 0;
    if (rd) begin
      bq.delete();
      epoch++;
      mpc        = {rpc[31:2], 2'b00};
      consume_pc = mpc;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    stall_d = 0; redirect = 0; redirect_pc = 0;
    mpc = RESET_PC; consume_pc = RESET_PC;

    // Reset values
    @(negedge clk); #1;
    chk("rst_valid_f", valid_f, 1'b0);
    chk("rst_inst_f", inst_f, 32'h0);
    chk("rst_pc_f", pc_f, 32'h0);
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_imem_addr", imem_addr, RESET_PC);
    @(negedge clk);
    rst = 1'b0;

    // Streaming with a 1-cycle memory returning word = addr
    word_is_addr = 1; lat = 1; gnt_delay = 0; gnt_random = 0;
    do_cycle(0, 0, 0);
    do_cycle(0, 0, 0);
    chk("latency_valid", valid_f, 1'b1);
    chk("latency_pc", pc_f, RESET_PC);
    for (int i = 0; i < 8; i++) do_cycle(0, 0, 0);

    // Decode stall for 5 cycles
    hold_pc = pc_f;
    for (int i = 0; i < 5; i++) do_cycle(1, 0, 0);
    chk("stall_hold_pc", pc_f, hold_pc);
    for (int i = 0; i < 8; i++) do_cycle(0, 0, 0);

    // Slow memory: gnt after 2 waiting cycles, 3-cycle response
    word_is_addr = 0; lat = 3; gnt_delay = 2; max_inflight = 0;
    for (int i = 0; i < 30; i++) do_cycle($urandom_range(0, 3) == 0, 0, 0);
    chk("inflight_bound", max_inflight <= DEPTH, 1'b1);

    // Redirect while two requests are outstanding
    gnt_delay = 0; n = 0;
    while (memq.size() != 2 && n < 20) begin do_cycle(0, 0, 0); n++; end
    chk("two_outstanding", memq.size(), 2);
    do_cycle(0, 1, 32'h0040_0013);
    chk("redirect_addr", imem_addr, 32'h0040_0010);
    n = 0;
    while (!valid_f && n < 30) begin do_cycle(0, 0, 0); n++; end
    chk("redirect_first_pc", pc_f, 32'h0040_0010);
    for (int i = 0; i < 6; i++) do_cycle(0, 0, 0);

    // Redirect coinciding with rvalid and stall_d
    lat = 1; n = 0;
    while (!(memq.size() > 0 && memq[0].due <= cyc) && n < 20) begin do_cycle(0, 0, 0); n++; end
    chk("rvalid_pending", memq.size() > 0, 1'b1);
    do_cycle(1, 1, 32'h0000_1000);
    chk("redirect_rvalid_valid", valid_f, 1'b0);
    for (int i = 0; i < 4; i++) do_cycle(1, 0, 0);
    for (int i = 0; i < 6; i++) do_cycle(0, 0, 0);

    // PC wrap at the top of the address space
    do_cycle(0, 1, 32'hFFFF_FFFC);
    n = 0;
    while (imem_addr == 32'hFFFF_FFFC && n < 10) begin do_cycle(0, 0, 0); n++; end
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    for (int i = 0; i < 6; i++) do_cycle(0, 0, 0);

    // Random traffic
    word_is_addr = 0; gnt_random = 1;
    for (int i = 0; i < 1500; i++) begin
      lat = $urandom_range(1, 4);
      do_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0, $urandom);
    end

    // Asynchronous reset in the middle of a stream
    gnt_random = 0; lat = 1;
    for (int i = 0; i < 6; i++) do_cycle(0, 0, 0);
    chk("pre_rst_valid", valid_f, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", valid_f, 1'b0);
    chk("async_rst_req", imem_req, 1'b0);
    chk("async_rst_addr", imem_addr, RESET_PC);
    imem_rvalid = 0; imem_gnt = 0;
    memq.delete(); bq.delete(); epoch++; req_wait = 0;
    mpc = RESET_PC; consume_pc = RESET_PC;
    @(negedge clk);
    rst = 1'b0;
    do_cycle(0, 0, 0);
    do_cycle(0, 0, 0);
    chk("post_rst_pc", pc_f, RESET_PC);
    for (int i = 0; i < 4; i++) do_cycle(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
